mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter/controller sharing one 2:1 data mux between two packet
//  requesters (A = mux input a, B = mux input b). Grants whole packets, drives
//  the mux select from a registered grant, and forwards a valid/ready handshake.
//  Sits in front of a single downstream consumer; data path is mux only, no storage.
// PARAMETERS
//  DATA_WIDTH  8   width of a_data, b_data, out_data
//  MAX_BURST   16  max beats per grant before forced release (>=1, <=255)
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  a_valid      in   1           requester A beat valid
//  a_data       in   DATA_WIDTH  requester A beat data
//  a_last       in   1           requester A final beat of packet
//  a_ready      out  1           A beat accepted when a_valid & a_ready
//  b_valid      in   1           requester B beat valid
//  b_data       in   DATA_WIDTH  requester B beat data
//  b_last       in   1           requester B final beat of packet
//  b_ready      out  1           B beat accepted when b_valid & b_ready
//  out_valid    out  1           downstream beat valid
//  out_data     out  DATA_WIDTH  downstream data = sel ? b_data : a_data
//  out_last     out  1           downstream last = sel ? b_last : a_last
//  out_ready    in   1           downstream ready
//  sel          out  1           registered mux select (0 = A, 1 = B)
//  busy         out  1           1 while in GRANT_A or GRANT_B
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: state=IDLE, sel=0, busy=0, last_grant=B (so A wins first tie),
//   beat_cnt=0. Outputs then: a_ready=b_ready=out_valid=0.
//  FSM states: IDLE, GRANT_A, GRANT_B (registered).
//  IDLE: out_valid=0, a_ready=b_ready=0.
//   only a_valid -> GRANT_A, sel<=0; only b_valid -> GRANT_B, sel<=1;
//   both -> grant the one != last_grant; neither -> stay.
//   Arbitration latency: first beat can transfer 1 cycle after request seen.
//  GRANT_A: out_valid=a_valid, a_ready=out_ready, b_ready=0 (mirror for B).
//   Beat transfer = out_valid & out_ready; each transfer beat_cnt++.
//   Release when transfer with out_last=1 OR beat_cnt reaches MAX_BURST-1 on
//   a transfer: -> IDLE, last_grant<=granted side, beat_cnt<=0.
//   Forced release mid-packet: remaining beats re-arbitrate normally.
//  No back-to-back grant: every release spends >=1 cycle in IDLE (bubble).
//  sel changes only on IDLE->GRANT transitions; stable for the whole grant.
//  busy = (state != IDLE).
//  Requester dropping valid mid-grant: grant held, out_valid=0, no timeout.
//  out_ready low: no transfer, counters/state hold; data held by requester.
//  Single-beat packet (last on first beat): GRANT for 1 cycle if out_ready=1.
//  MAX_BURST=1: every transfer releases.
//  Async reset mid-packet: immediate return to reset values; partial packet
//   is abandoned, no recovery.
//  beat_cnt width = clog2(MAX_BURST)+1, never wraps (cleared on release).
//  out_data/out_last are combinational through the mux; no added latency.
// TESTING
//  1 Reset: rst_n=0 with a_valid=b_valid=1 -> sel=0, busy=0, out_valid=0,
//    a_ready=b_ready=0; async: rst_n falls mid-cycle -> outputs clear at once.
//  2 A only: 3-beat packet 0x11,0x22,0x33(last), out_ready=1 -> GRANT_A after 1
//    cycle, out_data 0x11,0x22,0x33 on 3 consecutive cycles, then IDLE.
//  3 Tie after reset: a_valid=b_valid=1, 2-beat packets each, out_ready=1 ->
//    A packet, 1 IDLE bubble, B packet (sel 0 then 1), then A again.
//  4 Forced release: MAX_BURST=4, A sends 6-beat packet, B idle-then-valid ->
//    after 4 A beats IDLE, B granted, then A's remaining 2 beats.
//  5 Backpressure: out_ready toggled 1,0,0,1 during B packet -> a_ready/b_ready
//    follow out_ready, no beat lost/duplicated, sel stays 1 throughout.
//  6 Valid gap: A drops a_valid for 2 cycles mid-packet with B requesting ->
//    grant held on A, out_valid=0 for 2 cycles, B waits until A's last beat.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_rr_arbiter
//  Description : Packet-level round-robin arbiter that shares one 2:1 data
//                mux between two valid/ready requesters (A and B) feeding a
//                single downstream consumer. Whole packets are granted, a
//                grant is capped at MAX_BURST beats, and each release passes
//                through one IDLE bubble before the next grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_last,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_last,
  output logic                  b_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  sel,
  output logic                  busy
);

  // Counter is one bit wider than needed to hold MAX_BURST-1; it is cleared
  // on every release so it never wraps.
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_A = 2'd1,
    S_GRANT_B = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_sel;
  logic             r_busy;
  logic             r_last_grant;   // 0 = A last owned the mux, 1 = B
  logic [CNT_W-1:0] r_beat_cnt;

  logic w_in_a;
  logic w_in_b;
  logic w_out_valid;
  logic w_out_last;
  logic w_xfer;
  logic w_release;
  logic w_pick_a;

  // Handshake steering: only the granted side sees downstream ready, and the
  // mux follows the registered select so data/last add no latency.
  always_comb begin
    w_in_a      = (r_state == S_GRANT_A);
    w_in_b      = (r_state == S_GRANT_B);
    w_out_valid = (w_in_a & a_valid) | (w_in_b & b_valid);
    w_out_last  = r_sel ? b_last : a_last;
    w_xfer      = w_out_valid & out_ready;
    // Release on the packet's last beat or when the burst cap is reached.
    w_release   = w_xfer & (w_out_last | (r_beat_cnt == C_CNT_MAX));
    // A wins when it is alone, or on a tie when B owned the previous grant.
    w_pick_a    = a_valid & (~b_valid | r_last_grant);
  end

  assign a_ready   = w_in_a & out_ready;
  assign b_ready   = w_in_b & out_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_sel ? b_data : a_data;
  assign out_last  = w_out_last;
  assign sel       = r_sel;
  assign busy      = r_busy;

  // Arbitration FSM with registered select, busy flag and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_beat_cnt <= '0;
          if (w_pick_a) begin
            r_state <= S_GRANT_A;
            r_sel   <= 1'b0;
            r_busy  <= 1'b1;
          end else if (b_valid) begin
            r_state <= S_GRANT_B;
            r_sel   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_GRANT_A, S_GRANT_B: begin
          if (w_release) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_last_grant <= r_sel;
            r_beat_cnt   <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux2_rr_arbiter
//  Description : Directed self-checking bench for mux2_rr_arbiter
//                (MAX_BURST = 4 so the burst cap is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_rr_arbiter;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          a_valid, a_last, a_ready;
  logic [DW-1:0] a_data;
  logic          b_valid, b_last, b_ready;
  logic [DW-1:0] b_data;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic          sel, busy;

  int n_assert;
  int n_fail;

  mux2_rr_arbiter #(
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [DW-1:0] d, input logic l);
    a_valid = v; a_data = d; a_last = l;
  endtask

  task automatic drv_b(input logic v, input logic [DW-1:0] d, input logic l);
    b_valid = v; b_data = d; b_last = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // ---- 1: reset with both requesters valid
    rst_n = 1'b0; out_ready = 1'b1;
    drv_a(1'b1, 8'hAA, 1'b0);
    drv_b(1'b1, 8'hBB, 1'b0);
    tick(); tick(); #1;
    chk("rst_sel",       sel,       1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_a_ready",   a_ready,   1'b0);
    chk("rst_b_ready",   b_ready,   1'b0);
    drv_a(1'b0, 8'h00, 1'b0);
    drv_b(1'b0, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- 2: A-only 3-beat packet
    drv_a(1'b1, 8'h11, 1'b0); #1;
    chk("t2_idle_busy",  busy,      1'b0);
    chk("t2_idle_valid", out_valid, 1'b0);
    tick(); #1;
    chk("t2_b1_busy",  busy,      1'b1);
    chk("t2_b1_sel",   sel,       1'b0);
    chk("t2_b1_valid", out_valid, 1'b1);
    chk("t2_b1_data",  out_data,  8'h11);
    chk("t2_b1_ardy",  a_ready,   1'b1);
    tick(); drv_a(1'b1, 8'h22, 1'b0); #1;
    chk("t2_b2_data",  out_data,  8'h22);
    tick(); drv_a(1'b1, 8'h33, 1'b1); #1;
    chk("t2_b3_data",  out_data,  8'h33);
    chk("t2_b3_last",  out_last,  1'b1);
    tick(); drv_a(1'b0, 8'h00, 1'b0); #1;
    chk("t2_end_busy", busy,      1'b0);

    // ---- 3: tie after reset, A then bubble then B then A
    do_reset();
    drv_a(1'b1, 8'hA1, 1'b0);
    drv_b(1'b1, 8'hB1, 1'b0); #1;
    chk("t3_idle_busy", busy, 1'b0);
    tick(); #1;
    chk("t3_a1_sel",  sel,      1'b0);
    chk("t3_a1_data", out_data, 8'hA1);
    chk("t3_a1_brdy", b_ready,  1'b0);
    tick(); drv_a(1'b1, 8'hA2, 1'b1); #1;
    chk("t3_a2_data", out_data, 8'hA2);
    tick(); drv_a(1'b1, 8'hA3, 1'b1); #1;
    chk("t3_bubble_busy",  busy,      1'b0);
    chk("t3_bubble_valid", out_valid, 1'b0);
    tick(); #1;
    chk("t3_b1_sel",  sel,      1'b1);
    chk("t3_b1_data", out_data, 8'hB1);
    chk("t3_b1_brdy", b_ready,  1'b1);
    chk("t3_b1_ardy", a_ready,  1'b0);
    tick(); drv_b(1'b1, 8'hB2, 1'b1); #1;
    chk("t3_b2_data", out_data, 8'hB2);
    tick(); drv_b(1'b0, 8'h00, 1'b0); #1;
    chk("t3_bubble2_busy", busy, 1'b0);
    tick(); #1;
    chk("t3_a3_sel",  sel,      1'b0);
    chk("t3_a3_data", out_data, 8'hA3);
    tick(); drv_a(1'b0, 8'h00, 1'b0); #1;
    chk("t3_end_busy", busy, 1'b0);

    // ---- 4: forced release after 4 beats of a 6-beat A packet
    drv_a(1'b1, 8'hD0, 1'b0);
    tick(); #1;
    chk("t4_d0_data", out_data, 8'hD0);
    tick(); drv_a(1'b1, 8'hD1, 1'b0); #1;
    chk("t4_d1_data", out_data, 8'hD1);
    tick(); drv_a(1'b1, 8'hD2, 1'b0); drv_b(1'b1, 8'hEE, 1'b1); #1;
    chk("t4_d2_data", out_data, 8'hD2);
    tick(); drv_a(1'b1, 8'hD3, 1'b0); #1;
    chk("t4_d3_data", out_data, 8'hD3);
    chk("t4_d3_busy", busy,     1'b1);
    tick(); drv_a(1'b1, 8'hD4, 1'b0); #1;
    chk("t4_forced_busy", busy,    1'b0);
    chk("t4_forced_ardy", a_ready, 1'b0);
    tick(); #1;
    chk("t4_b_sel",  sel,      1'b1);
    chk("t4_b_data", out_data, 8'hEE);
    tick(); drv_b(1'b0, 8'h00, 1'b0); #1;
    chk("t4_bubble_busy", busy, 1'b0);
    tick(); #1;
    chk("t4_d4_sel",  sel,      1'b0);
    chk("t4_d4_data", out_data, 8'hD4);
    tick(); drv_a(1'b1, 8'hD5, 1'b1); #1;
    chk("t4_d5_data", out_data, 8'hD5);
    chk("t4_d5_last", out_last, 1'b1);
    tick(); drv_a(1'b0, 8'h00, 1'b0); #1;
    chk("t4_end_busy", busy, 1'b0);

    // ---- 5: backpressure during a B packet
    drv_b(1'b1, 8'hC1, 1'b0);
    tick(); out_ready = 1'b1; #1;
    chk("t5_c1_data", out_data, 8'hC1);
    chk("t5_c1_brdy", b_ready,  1'b1);
    tick(); drv_b(1'b1, 8'hC2, 1'b0); out_ready = 1'b0; #1;
    chk("t5_st1_brdy", b_ready,  1'b0);
    chk("t5_st1_sel",  sel,      1'b1);
    chk("t5_st1_data", out_data, 8'hC2);
    tick(); #1;
    chk("t5_st2_brdy", b_ready, 1'b0);
    chk("t5_st2_busy", busy,    1'b1);
    tick(); out_ready = 1'b1; #1;
    chk("t5_c2_brdy", b_ready,  1'b1);
    chk("t5_c2_data", out_data, 8'hC2);
    tick(); drv_b(1'b1, 8'hC3, 1'b1); #1;
    chk("t5_c3_data", out_data, 8'hC3);
    chk("t5_c3_sel",  sel,      1'b1);
    chk("t5_c3_busy", busy,     1'b1);
    tick(); drv_b(1'b0, 8'h00, 1'b0); #1;
    chk("t5_end_busy", busy, 1'b0);

    // ---- 6: A drops valid mid-packet while B waits
    drv_a(1'b1, 8'hE1, 1'b0);
    drv_b(1'b1, 8'hF1, 1'b1);
    tick(); #1;
    chk("t6_e1_sel",  sel,      1'b0);
    chk("t6_e1_data", out_data, 8'hE1);
    tick(); drv_a(1'b0, 8'h00, 1'b0); #1;
    chk("t6_gap1_valid", out_valid, 1'b0);
    chk("t6_gap1_busy",  busy,      1'b1);
    chk("t6_gap1_brdy",  b_ready,   1'b0);
    tick(); #1;
    chk("t6_gap2_valid", out_valid, 1'b0);
    chk("t6_gap2_sel",   sel,       1'b0);
    tick(); drv_a(1'b1, 8'hE2, 1'b1); #1;
    chk("t6_e2_valid", out_valid, 1'b1);
    chk("t6_e2_data",  out_data,  8'hE2);
    tick(); drv_a(1'b0, 8'h00, 1'b0); #1;
    chk("t6_bubble_busy", busy, 1'b0);
    tick(); #1;
    chk("t6_f1_sel",  sel,      1'b1);
    chk("t6_f1_data", out_data, 8'hF1);

    // ---- async reset mid-grant (B granted, sel = 1)
    drv_b(1'b1, 8'hF2, 1'b0);
    tick(); tick(); #1;
    chk("ar_pre_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_sel",       sel,       1'b0);
    chk("ar_busy",      busy,      1'b0);
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_b_ready",   b_ready,   1'b0);
    drv_b(1'b0, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
